// File: rtl/frame_snap_ctrl.sv
// rtl/frame_snap_ctrl.sv - frame-aligned SD sector write sequencer with slot ring
// Turns a key press into a burst of sector writes per frame, in single-shot or continuous mode.
module frame_snap_ctrl #(
  parameter int          H_PIXEL      = 1280,
  parameter int          V_PIXEL      = 720,
  parameter int          PIX_BYTES    = 2,
  parameter int          SECTOR_BYTES = 512,
  parameter logic [31:0] BASE_SECTOR  = 32'd16000,
  parameter int          SLOT_NUM     = 4,
  parameter int          BUSY_TIMEOUT = 1000,
  localparam int         SLOT_W       = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key_flag,
  input  logic              mode,
  input  logic              sd_init_end,
  input  logic              sof,
  input  logic              wr_busy,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic              frame,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              cap_done,
  output logic              err,
  output logic              busy
);

  localparam int          SPF   = (H_PIXEL * V_PIXEL * PIX_BYTES + SECTOR_BYTES - 1) / SECTOR_BYTES;
  localparam logic [31:0] SPF32 = 32'(SPF);
  localparam int          TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOT_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WR_REQ,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_wr_en;
  logic [31:0]       r_wr_addr;
  logic              r_frame;
  logic [SLOT_W-1:0] r_slot_idx;
  logic              r_cap_done;
  logic              r_err;
  logic              r_busy;
  logic              r_mode;
  logic              r_stop_req;
  logic [31:0]       r_sec_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [31:0]       w_sec_nxt;
  logic [31:0]       w_addr_nxt;
  logic              w_timeout;
  logic              w_in_write;
  logic              w_nxt_write;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (key_flag && sd_init_end) w_state_nxt = S_ARM;
      // cancel takes priority over a coincident start of frame
      S_ARM:     if (key_flag) w_state_nxt = S_IDLE;
                 else if (sof) w_state_nxt = S_WR_REQ;
      S_WR_REQ:  w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (wr_busy) w_state_nxt = S_WAIT_LO;
                 else if (r_to_cnt == TO_MAX) w_state_nxt = S_IDLE;
      S_WAIT_LO: if (!wr_busy) w_state_nxt = S_NEXT;
      S_NEXT:    w_state_nxt = (r_sec_cnt == SPF32 - 32'd1) ? S_DONE : S_WR_REQ;
      S_DONE:    w_state_nxt = (r_mode && !r_stop_req && !key_flag) ? S_ARM : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sec_nxt   = (r_state == S_NEXT) ? r_sec_cnt + 32'd1 : 32'd0;
  assign w_addr_nxt  = BASE_SECTOR + 32'(r_slot_idx) * SPF32 + w_sec_nxt;
  assign w_timeout   = (r_state == S_WAIT_HI) && !wr_busy && (r_to_cnt == TO_MAX);
  assign w_in_write  = (r_state == S_WR_REQ) || (r_state == S_WAIT_HI) ||
                       (r_state == S_WAIT_LO) || (r_state == S_NEXT) || (r_state == S_DONE);
  assign w_nxt_write = (w_state_nxt == S_WR_REQ) || (w_state_nxt == S_WAIT_HI) ||
                       (w_state_nxt == S_WAIT_LO) || (w_state_nxt == S_NEXT) ||
                       (w_state_nxt == S_DONE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 32'd0;
      r_frame    <= 1'b0;
      r_slot_idx <= '0;
      r_cap_done <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_mode     <= 1'b0;
      r_stop_req <= 1'b0;
      r_sec_cnt  <= 32'd0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_en    <= (w_state_nxt == S_WR_REQ);
      r_frame    <= w_nxt_write;
      r_cap_done <= (w_state_nxt == S_DONE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_to_cnt   <= (r_state == S_WAIT_HI) ? r_to_cnt + TO_W'(1) : '0;
      if (w_state_nxt == S_WR_REQ) begin
        r_wr_addr <= w_addr_nxt;
        r_sec_cnt <= w_sec_nxt;
      end
      if (r_state == S_IDLE && w_state_nxt == S_ARM) begin
        r_mode <= mode;
        r_err  <= 1'b0;
      end
      if (w_timeout)
        r_err <= 1'b1;
      // a stop request lets the frame in flight finish; clearing on IDLE wins
      if (w_in_write && key_flag && r_mode)
        r_stop_req <= 1'b1;
      if (w_state_nxt == S_IDLE)
        r_stop_req <= 1'b0;
      if (r_state == S_DONE)
        r_slot_idx <= (r_slot_idx == SLOT_MAX) ? '0 : r_slot_idx + SLOT_W'(1);
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign frame    = r_frame;
  assign slot_idx = r_slot_idx;
  assign cap_done = r_cap_done;
  assign err      = r_err;
  assign busy     = r_busy;

endmodule

// File: doc/frame_snap_ctrl.md
Name: frame_snap_ctrl

Overview:
Parametrised frame-capture sequencer in the clk_50m domain. It turns a debounced key press into a frame-aligned burst of SD-card sector writes, handshaking with sd_ctrl through wr_en, wr_addr and wr_busy. It drives the frame select that hands the pixel read stream to the SD writer. It supersedes the fixed single-frame write control with a ring of capture slots, single-shot and continuous modes, and a busy-timeout error path.

Parameters:
H_PIXEL, 1280, active pixels per line
V_PIXEL, 720, active lines per frame
PIX_BYTES, 2, bytes per pixel (RGB565)
SECTOR_BYTES, 512, bytes per SD sector
BASE_SECTOR, 32'd16000, first sector of slot 0
SLOT_NUM, 4, frame slots in ring (>=1)
BUSY_TIMEOUT, 1000, max cycles from wr_en to wr_busy rise
Derived: SPF = ceil(H_PIXEL*V_PIXEL*PIX_BYTES/SECTOR_BYTES) (3600 at default); SLOT_W = max(1,clog2(SLOT_NUM)).

Ports:
sys_clk  in  1  50 MHz clock
sys_rst_n  in  1  async active-low reset
key_flag  in  1  one-cycle debounced key pulse
mode  in  1  0 = single-shot, 1 = continuous; sampled on IDLE->ARM
sd_init_end  in  1  SD init complete
sof  in  1  one-cycle start-of-frame pulse, already synchronised to sys_clk
wr_busy  in  1  sd_ctrl write busy
wr_en  out  1  one-cycle sector write start
wr_addr  out  32  sector address, stable from wr_en until wr_busy falls
frame  out  1  1 = capture owns pixel read stream
slot_idx  out  SLOT_W  slot being or next to be written
cap_done  out  1  one-cycle pulse per completed frame
err  out  1  sticky timeout flag, cleared on next accepted start
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE. wr_en=0, wr_addr=0, frame=0, slot_idx=0, cap_done=0, err=0, busy=0. Sector counter=0, stop_req=0, timeout counter=0.
- IDLE: key_flag & sd_init_end -> ARM. Latch mode, clear err. key_flag while sd_init_end=0 is ignored.
- ARM: wait for sof. On sof -> WR_REQ with sector_cnt=0, frame=1 from the next cycle. key_flag in ARM cancels to IDLE (no write, no cap_done). If sof and key_flag coincide, cancel wins.
- WR_REQ: one cycle; wr_en=1; wr_addr = BASE_SECTOR + slot_idx*SPF + sector_cnt, registered the same cycle wr_en rises. -> WAIT_HI.
- WAIT_HI: wr_busy=1 -> WAIT_LO. Timeout counter reaching BUSY_TIMEOUT -> IDLE with err=1, frame=0, slot_idx unchanged, no cap_done.
- WAIT_LO: wr_busy=0 -> NEXT.
- NEXT: sector_cnt==SPF-1 -> DONE; else sector_cnt+1 -> WR_REQ.
- DONE: one cycle. cap_done=1, frame=0 next cycle. slot_idx wraps: SLOT_NUM-1 -> 0. Then continuous mode with stop_req=0 -> ARM; otherwise -> IDLE with stop_req cleared.
- key_flag in WR_REQ/WAIT_HI/WAIT_LO/NEXT/DONE: continuous mode sets stop_req (the current frame always completes); single-shot mode ignores it.
- frame stays 1 from the cycle after sof-accept through the cycle of DONE.
- Address arithmetic is 32-bit unsigned. Overflow past 2^32 wraps and is a configuration error, not detected.
- Latency: sof -> first wr_en = 1 cycle. Minimum sector period = 4 cycles plus the wr_busy duration.

Test Plan:
- Single-shot (H=64, V=8, SPF=2, BASE=100, SLOT_NUM=2; wr_busy model high 10 cycles, 3 cycles after wr_en): key, sof -> wr_en twice at wr_addr 100, 101; cap_done once; slot_idx=1; return to IDLE; frame high across both sectors only.
- Slot wrap: four single-shot captures -> base addresses 100, 102, 100, 102; slot_idx sequence 1, 0, 1, 0.
- Continuous with stop: mode=1, key, three sofs, key mid-frame 2 -> frames 1 and 2 complete (addresses 100..103), no wr_en for frame 3, IDLE after second cap_done.
- Cancel/ignore: key in ARM before sof -> IDLE, no wr_en. Key with sd_init_end=0 -> stays IDLE, busy=0. Key coinciding with sof in ARM -> cancel.
- Timeout (BUSY_TIMEOUT=20, wr_busy stuck 0): err=1, frame=0, IDLE, slot_idx unchanged; the next key clears err.
- Reset mid-write (sys_rst_n low in WAIT_LO): all outputs 0 immediately and asynchronously; after release, a key press restarts at address 100.
